// File: rtl/wm8731_pkg.sv
// Shared definitions for the WM8731 control-port target: register indices,
// power-on register values and the control FSM state encoding.
package wm8731_pkg;

  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 9;
  localparam int NUM_REGS = 10;

  localparam logic [ADDR_W-1:0] REG_LLINE  = 7'h00;
  localparam logic [ADDR_W-1:0] REG_RLINE  = 7'h01;
  localparam logic [ADDR_W-1:0] REG_LHP    = 7'h02;
  localparam logic [ADDR_W-1:0] REG_RHP    = 7'h03;
  localparam logic [ADDR_W-1:0] REG_APATH  = 7'h04;
  localparam logic [ADDR_W-1:0] REG_DPATH  = 7'h05;
  localparam logic [ADDR_W-1:0] REG_PWR    = 7'h06;
  localparam logic [ADDR_W-1:0] REG_IFACE  = 7'h07;
  localparam logic [ADDR_W-1:0] REG_SRATE  = 7'h08;
  localparam logic [ADDR_W-1:0] REG_ACTIVE = 7'h09;
  localparam logic [ADDR_W-1:0] REG_RESET  = 7'h0F;

  // Codec power-on values, indexed by register number.
  localparam logic [DATA_W-1:0] REG_DEFAULTS [NUM_REGS] = '{
    9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
    9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_BYTE_HI,
    ST_ACK_HI,
    ST_BYTE_LO,
    ST_ACK_LO,
    ST_IGNORE
  } state_t;

  // A word is accepted if it targets a real register or the reset register.
  function automatic logic reg_is_valid(input logic [ADDR_W-1:0] addr);
    return (addr < 7'(NUM_REGS)) || (addr == REG_RESET);
  endfunction

endpackage

// File: rtl/wm8731_i2c_target_if.sv
// SCL plus the register-commit and readback signals between the codec model
// and whatever consumes it. SDA stays a plain inout on the target.
interface wm8731_i2c_target_if;
  import wm8731_pkg::*;

  logic              i2c_scl;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [3:0]        rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              codec_active;
  logic              bus_busy;
  logic              err_pulse;

  modport slave (
    input  i2c_scl, rd_addr,
    output wr_valid, wr_addr, wr_data, rd_data, codec_active, bus_busy, err_pulse
  );

  modport master (
    output i2c_scl, rd_addr,
    input  wr_valid, wr_addr, wr_data, rd_data, codec_active, bus_busy, err_pulse
  );

endinterface

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain and derives single-clk strobes for
// SCL edges and START/STOP conditions. Strobes are combinational from the
// last synchronizer stage and the edge register.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_reg;
  logic [SYNC_STAGES-1:0] sda_sync_reg;
  logic                   scl_d_reg;
  logic                   sda_d_reg;
  logic                   scl_s;
  logic                   sda_s;

  // Synchronizer chains and edge register; reset to the idle-high bus level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_d_reg    <= 1'b1;
      sda_d_reg    <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda};
      scl_d_reg    <= scl_s;
      sda_d_reg    <= sda_s;
    end
  end

  assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
  assign sda_level = sda_s;
  assign scl_rise  = scl_s & ~scl_d_reg;
  assign scl_fall  = ~scl_s & scl_d_reg;
  // SDA may only move with SCL high for START/STOP, so require SCL high on both samples.
  assign start_det = scl_s & scl_d_reg & sda_d_reg & ~sda_s;
  assign stop_det  = scl_s & scl_d_reg & ~sda_d_reg & sda_s;

endmodule

// File: rtl/wm8731_i2c_target.sv
// WM8731 2-wire control-port model: decodes write transactions, ACKs each
// byte, splits 16-bit words into 7-bit address / 9-bit data and keeps a
// shadow copy of the codec register map.
module wm8731_i2c_target
  import wm8731_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  inout  wire                  i2c_sda,
  wm8731_i2c_target_if.slave   bus
);

  logic sda_level, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl       (bus.i2c_scl),
    .sda       (i2c_sda),
    .sda_level (sda_level),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t            state_reg, state_next;
  logic [2:0]        bit_cnt_reg, bit_cnt_next;
  logic [6:0]        shift_reg, shift_next;
  logic [7:0]        byte_hi_reg, byte_hi_next;
  logic              sda_oe_reg, sda_oe_next;
  logic              extra_reg, extra_next;
  logic              busy_reg, busy_next;
  logic              wr_valid_reg, wr_valid_next;
  logic              err_reg, err_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [DATA_W-1:0] wr_data_reg, wr_data_next;

  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] commit_addr;
  logic [DATA_W-1:0] commit_data;
  logic              in_word;
  logic              reg_we;
  logic              restore_all;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [DATA_W-1:0]               rd_data_c;

  // The byte completed by the current SCL rise and the word it would form.
  assign rx_byte     = {shift_reg, sda_level};
  assign commit_addr = byte_hi_reg[7:1];
  assign commit_data = {byte_hi_reg[0], rx_byte};
  assign in_word     = (state_reg == ST_BYTE_HI) || (state_reg == ST_ACK_HI) ||
                       (state_reg == ST_BYTE_LO);

  // FSM state and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      byte_hi_reg  <= '0;
      sda_oe_reg   <= 1'b0;
      extra_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      wr_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      byte_hi_reg  <= byte_hi_next;
      sda_oe_reg   <= sda_oe_next;
      extra_reg    <= extra_next;
      busy_reg     <= busy_next;
      wr_valid_reg <= wr_valid_next;
      err_reg      <= err_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
    end
  end

  // Next-state logic; bus conditions win over bit sampling in the same clk.
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    byte_hi_next  = byte_hi_reg;
    sda_oe_next   = sda_oe_reg;
    extra_next    = extra_reg;
    busy_next     = busy_reg;
    wr_valid_next = 1'b0;
    err_next      = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    reg_we        = 1'b0;
    restore_all   = 1'b0;

    if (start_det) begin
      state_next   = ST_ADDR;
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
      extra_next   = 1'b0;
      busy_next    = 1'b1;
      err_next     = in_word;
    end else if (stop_det) begin
      state_next   = ST_IDLE;
      sda_oe_next  = 1'b0;
      extra_next   = 1'b0;
      busy_next    = 1'b0;
      err_next     = in_word;
    end else begin
      unique case (state_reg)
        ST_IDLE: ;
        ST_ADDR: begin
          if (scl_rise) begin
            shift_next   = rx_byte[6:0];
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              if ((rx_byte[7:1] == DEV_ADDR) && !rx_byte[0])
                state_next = ST_ADDR_ACK;
              else
                state_next = ST_IGNORE;
            end
          end
        end
        // First SCL fall ends the 8th bit: pull SDA low. Second fall ends the ACK clock.
        ST_ADDR_ACK, ST_ACK_HI, ST_ACK_LO: begin
          if (scl_fall) begin
            if (!sda_oe_reg) begin
              sda_oe_next = 1'b1;
            end else begin
              sda_oe_next  = 1'b0;
              bit_cnt_next = '0;
              if (state_reg == ST_ADDR_ACK) begin
                state_next = ST_BYTE_HI;
              end else if (state_reg == ST_ACK_HI) begin
                state_next = ST_BYTE_LO;
              end else begin
                state_next = ST_IGNORE;
                extra_next = 1'b1;
              end
            end
          end
        end
        ST_BYTE_HI: begin
          if (scl_rise) begin
            shift_next   = rx_byte[6:0];
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              byte_hi_next = rx_byte;
              state_next   = ST_ACK_HI;
            end
          end
        end
        ST_BYTE_LO: begin
          if (scl_rise) begin
            shift_next   = rx_byte[6:0];
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              state_next = ST_ACK_LO;
              if (reg_is_valid(commit_addr)) begin
                wr_valid_next = 1'b1;
                wr_addr_next  = commit_addr;
                wr_data_next  = commit_data;
                if (commit_addr == REG_RESET)
                  restore_all = 1'b1;
                else
                  reg_we = 1'b1;
              end else begin
                err_next = 1'b1;
              end
            end
          end
        end
        // Unaddressed traffic or bytes past the first word; the latter flag one error.
        ST_IGNORE: begin
          if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if ((bit_cnt_reg == 3'd7) && extra_reg) begin
              err_next   = 1'b1;
              extra_next = 1'b0;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Shadow register file, one flop group per codec register.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [DATA_W-1:0] val_reg;

    // Load on a matching commit; a reset-register write restores every default.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        val_reg <= REG_DEFAULTS[gi];
      else if (restore_all)
        val_reg <= REG_DEFAULTS[gi];
      else if (reg_we && (commit_addr == 7'(gi)))
        val_reg <= commit_data;
    end

    assign regs[gi] = val_reg;
  end

  // Readback mux; indices past the map read as zero.
  always_comb begin
    rd_data_c = '0;
    if (bus.rd_addr < 4'(NUM_REGS))
      rd_data_c = regs[bus.rd_addr];
  end

  assign i2c_sda          = sda_oe_reg ? 1'b0 : 1'bz;
  assign bus.wr_valid     = wr_valid_reg;
  assign bus.wr_addr      = wr_addr_reg;
  assign bus.wr_data      = wr_data_reg;
  assign bus.rd_data      = rd_data_c;
  assign bus.codec_active = regs[4'(REG_ACTIVE)][0];
  assign bus.bus_busy     = busy_reg;
  assign bus.err_pulse    = err_reg;

endmodule

// File: tb/tb_wm8731_i2c_target.sv
// Bit-banged I2C master driving the WM8731 target model. Register commits
// are checked against a queue of expected (address, data) words.
module tb_wm8731_i2c_target;

  logic clk = 1'b0;
  logic reset;
  logic sda_m;
  wire  i2c_sda;

  wm8731_i2c_target_if bus();

  assign i2c_sda = sda_m ? 1'bz : 1'b0;
  pullup (i2c_sda);

  wm8731_i2c_target #(.DEV_ADDR(7'h1A), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .i2c_sda (i2c_sda),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int err_cnt    = 0;
  int drive_cnt  = 0;

  logic [15:0] exp_q[$];
  logic [8:0]  dflt [10] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                             9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
  logic [8:0]  model [10];

  logic prev_valid = 1'b0;
  logic prev_drive = 1'b0;
  logic prev_scl   = 1'b1;

  // Scoreboard and bus monitor, sampled on the falling clk edge.
  always @(negedge clk) begin
    logic [15:0] exp_w;
    logic        drive;
    drive = sda_m && (i2c_sda === 1'b0);
    if (!reset) begin
      if (bus.err_pulse) err_cnt++;
      if (drive) drive_cnt++;
      if (bus.wr_valid) begin
        assert_cnt++;
        if (prev_valid) begin
          fail_cnt++;
          $display("FAIL wr_valid_width: wr_valid high on consecutive clks, required one-clk pulse");
        end
        if (exp_q.size() == 0) begin
          fail_cnt++;
          $display("FAIL wr_unexpected: got addr %h data %h, required no commit", bus.wr_addr, bus.wr_data);
        end else begin
          exp_w = exp_q.pop_front();
          if ({bus.wr_addr, bus.wr_data} !== exp_w) begin
            fail_cnt++;
            $display("FAIL wr_commit: got addr %h data %h, required addr %h data %h",
                     bus.wr_addr, bus.wr_data, exp_w[15:9], exp_w[8:0]);
          end else begin
            $display("commit addr %h data %h", bus.wr_addr, bus.wr_data);
          end
        end
      end
      if (prev_scl && bus.i2c_scl) begin
        assert_cnt++;
        if (drive !== prev_drive) begin
          fail_cnt++;
          $display("FAIL sda_while_scl_high: target drive changed %b->%b, required stable", prev_drive, drive);
        end
      end
    end
    prev_valid = bus.wr_valid;
    prev_drive = drive;
    prev_scl   = bus.i2c_scl;
  end

  task automatic qwait();
    repeat (8) @(posedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    qwait();
    bus.i2c_scl = 1'b1;
    qwait();
    sda_m = 1'b0;
    qwait();
    bus.i2c_scl = 1'b0;
    qwait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    qwait();
    bus.i2c_scl = 1'b1;
    qwait();
    sda_m = 1'b1;
    qwait();
    qwait();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i];
      qwait();
      bus.i2c_scl = 1'b1;
      qwait();
      qwait();
      bus.i2c_scl = 1'b0;
      qwait();
    end
    sda_m = 1'b1;
    qwait();
    bus.i2c_scl = 1'b1;
    qwait();
    ack = (i2c_sda === 1'b0);
    qwait();
    bus.i2c_scl = 1'b0;
    qwait();
  endtask

  task automatic write_word(input logic [7:0] hi, input logic [7:0] lo, output logic [2:0] acks);
    i2c_start();
    send_byte(8'h34, acks[2]);
    send_byte(hi, acks[1]);
    send_byte(lo, acks[0]);
    i2c_stop();
    qwait();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sda_m = 1'b1;
    bus.i2c_scl = 1'b1;
    bus.rd_addr = 4'd0;
    repeat (4) @(posedge clk);
    reset = 1'b0;
    @(negedge clk);
    assert_cnt++;
    if ({bus.wr_valid, bus.err_pulse, bus.bus_busy, bus.wr_addr, bus.wr_data} !== 19'd0) begin
      fail_cnt++;
      $display("FAIL reset_outputs: got valid %b err %b busy %b addr %h data %h, required all 0",
               bus.wr_valid, bus.err_pulse, bus.bus_busy, bus.wr_addr, bus.wr_data);
    end
    assert_cnt++;
    if (i2c_sda !== 1'b1) begin
      fail_cnt++;
      $display("FAIL reset_sda: got %b, required released (1)", i2c_sda);
    end
    for (int i = 0; i < 16; i++) begin
      bus.rd_addr = 4'(i);
      #1;
      assert_cnt++;
      if (bus.rd_data !== ((i < 10) ? dflt[i] : 9'h000)) begin
        fail_cnt++;
        $display("FAIL reset_regfile[%0d]: got %h, required %h", i, bus.rd_data, (i < 10) ? dflt[i] : 9'h000);
      end
    end
    for (int i = 0; i < 10; i++) model[i] = dflt[i];
    $display("test_reset done");
  endtask

  task automatic test_write_active();
    logic [2:0] acks;
    exp_q.push_back({7'h09, 9'h001});
    model[9] = 9'h001;
    write_word(8'h12, 8'h01, acks);
    assert_cnt++;
    if (acks !== 3'b111) begin
      fail_cnt++;
      $display("FAIL active_acks: got %b, required 111", acks);
    end
    assert_cnt++;
    if (bus.codec_active !== 1'b1) begin
      fail_cnt++;
      $display("FAIL codec_active_set: got %b, required 1", bus.codec_active);
    end
    bus.rd_addr = 4'd9;
    #1;
    assert_cnt++;
    if (bus.rd_data !== 9'h001) begin
      fail_cnt++;
      $display("FAIL active_rd: got %h, required 001", bus.rd_data);
    end
    $display("test_write_active acks %b", acks);
  endtask

  task automatic test_nack();
    logic ack;
    int   d0;
    d0 = drive_cnt;
    i2c_start();
    assert_cnt++;
    if (bus.bus_busy !== 1'b1) begin
      fail_cnt++;
      $display("FAIL nack_busy_high: got %b, required 1", bus.bus_busy);
    end
    send_byte(8'h36, ack);
    i2c_stop();
    assert_cnt++;
    if (ack !== 1'b0) begin
      fail_cnt++;
      $display("FAIL nack_addr: got ack %b, required 0", ack);
    end
    assert_cnt++;
    if (bus.bus_busy !== 1'b0) begin
      fail_cnt++;
      $display("FAIL nack_busy_low: got %b, required 0", bus.bus_busy);
    end
    assert_cnt++;
    if (drive_cnt !== d0) begin
      fail_cnt++;
      $display("FAIL nack_sda_driven: got %0d driven clks, required 0", drive_cnt - d0);
    end
    $display("test_nack ack %b", ack);
  endtask

  task automatic test_reset_reg();
    logic [2:0] acks;
    exp_q.push_back({7'h04, 9'h079});
    write_word(8'h08, 8'h79, acks);
    bus.rd_addr = 4'd4;
    #1;
    assert_cnt++;
    if (bus.rd_data !== 9'h079) begin
      fail_cnt++;
      $display("FAIL apath_write1: got %h, required 079", bus.rd_data);
    end
    exp_q.push_back({7'h04, 9'h123});
    write_word(8'h09, 8'h23, acks);
    #1;
    assert_cnt++;
    if (bus.rd_data !== 9'h123) begin
      fail_cnt++;
      $display("FAIL apath_write2: got %h, required 123", bus.rd_data);
    end
    exp_q.push_back({7'h0F, 9'h000});
    write_word(8'h1E, 8'h00, acks);
    for (int i = 0; i < 10; i++) model[i] = dflt[i];
    assert_cnt++;
    if (acks !== 3'b111) begin
      fail_cnt++;
      $display("FAIL reset_reg_acks: got %b, required 111", acks);
    end
    assert_cnt++;
    if (bus.codec_active !== 1'b0) begin
      fail_cnt++;
      $display("FAIL reset_reg_active: got %b, required 0", bus.codec_active);
    end
    for (int i = 0; i < 10; i++) begin
      bus.rd_addr = 4'(i);
      #1;
      assert_cnt++;
      if (bus.rd_data !== model[i]) begin
        fail_cnt++;
        $display("FAIL reset_reg_file[%0d]: got %h, required %h", i, bus.rd_data, model[i]);
      end
    end
    $display("test_reset_reg done");
  endtask

  task automatic test_invalid();
    logic [2:0] acks;
    int         e0;
    e0 = err_cnt;
    write_word(8'h1C, 8'h00, acks);
    assert_cnt++;
    if (acks !== 3'b111) begin
      fail_cnt++;
      $display("FAIL invalid_acks: got %b, required 111", acks);
    end
    assert_cnt++;
    if (err_cnt - e0 !== 1) begin
      fail_cnt++;
      $display("FAIL invalid_err: got %0d pulses, required 1", err_cnt - e0);
    end
    for (int i = 0; i < 10; i++) begin
      bus.rd_addr = 4'(i);
      #1;
      assert_cnt++;
      if (bus.rd_data !== model[i]) begin
        fail_cnt++;
        $display("FAIL invalid_file[%0d]: got %h, required %h", i, bus.rd_data, model[i]);
      end
    end
    $display("test_invalid acks %b", acks);
  endtask

  task automatic test_extra_byte();
    logic [3:0] acks;
    int         e0;
    e0 = err_cnt;
    i2c_start();
    send_byte(8'h34, acks[3]);
    send_byte(8'h08, acks[2]);
    exp_q.push_back({7'h04, 9'h012});
    model[4] = 9'h012;
    send_byte(8'h12, acks[1]);
    send_byte(8'h55, acks[0]);
    i2c_stop();
    qwait();
    assert_cnt++;
    if (acks !== 4'b1110) begin
      fail_cnt++;
      $display("FAIL extra_acks: got %b, required 1110", acks);
    end
    assert_cnt++;
    if (err_cnt - e0 !== 1) begin
      fail_cnt++;
      $display("FAIL extra_err: got %0d pulses, required 1", err_cnt - e0);
    end
    bus.rd_addr = 4'd4;
    #1;
    assert_cnt++;
    if (bus.rd_data !== 9'h012) begin
      fail_cnt++;
      $display("FAIL extra_rd: got %h, required 012", bus.rd_data);
    end
    $display("test_extra_byte acks %b", acks);
  endtask

  task automatic test_truncated();
    logic ack;
    int   e0;
    e0 = err_cnt;
    i2c_start();
    send_byte(8'h34, ack);
    send_byte(8'h12, ack);
    i2c_stop();
    qwait();
    assert_cnt++;
    if (err_cnt - e0 !== 1) begin
      fail_cnt++;
      $display("FAIL stop_midword_err: got %0d pulses, required 1", err_cnt - e0);
    end
    i2c_start();
    send_byte(8'h34, ack);
    send_byte(8'h12, ack);
    i2c_start();
    send_byte(8'h34, ack);
    send_byte(8'h10, ack);
    exp_q.push_back({7'h08, 9'h005});
    model[8] = 9'h005;
    send_byte(8'h05, ack);
    i2c_stop();
    qwait();
    assert_cnt++;
    if (err_cnt - e0 !== 2) begin
      fail_cnt++;
      $display("FAIL rstart_midword_err: got %0d pulses, required 2", err_cnt - e0);
    end
    bus.rd_addr = 4'd8;
    #1;
    assert_cnt++;
    if (bus.rd_data !== 9'h005) begin
      fail_cnt++;
      $display("FAIL rstart_rd: got %h, required 005", bus.rd_data);
    end
    bus.rd_addr = 4'd9;
    #1;
    assert_cnt++;
    if (bus.rd_data !== model[9]) begin
      fail_cnt++;
      $display("FAIL truncated_no_write: got %h, required %h", bus.rd_data, model[9]);
    end
    $display("test_truncated done");
  endtask

  task automatic test_reset_mid();
    logic [2:0] acks;
    logic       ack;
    int         e0;
    exp_q.push_back({7'h00, 9'h1FF});
    write_word(8'h01, 8'hFF, acks);
    bus.rd_addr = 4'd0;
    #1;
    assert_cnt++;
    if (bus.rd_data !== 9'h1FF) begin
      fail_cnt++;
      $display("FAIL llin_write: got %h, required 1FF", bus.rd_data);
    end
    i2c_start();
    send_byte(8'h34, ack);
    send_byte(8'h00, ack);
    for (int i = 0; i < 3; i++) begin
      sda_m = 1'b1;
      qwait();
      bus.i2c_scl = 1'b1;
      qwait();
      qwait();
      bus.i2c_scl = 1'b0;
      qwait();
    end
    sda_m = 1'b1;
    @(posedge clk);
    reset = 1'b1;
    #1;
    assert_cnt++;
    if (i2c_sda !== 1'b1) begin
      fail_cnt++;
      $display("FAIL reset_mid_sda: got %b, required released (1)", i2c_sda);
    end
    repeat (2) @(posedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) model[i] = dflt[i];
    #1;
    assert_cnt++;
    if (bus.rd_data !== 9'h097) begin
      fail_cnt++;
      $display("FAIL reset_mid_reg0: got %h, required 097", bus.rd_data);
    end
    e0 = err_cnt;
    bus.i2c_scl = 1'b1;
    qwait();
    qwait();
    exp_q.push_back({7'h00, 9'h055});
    model[0] = 9'h055;
    write_word(8'h00, 8'h55, acks);
    assert_cnt++;
    if (acks !== 3'b111) begin
      fail_cnt++;
      $display("FAIL reset_mid_acks: got %b, required 111", acks);
    end
    #1;
    assert_cnt++;
    if (bus.rd_data !== 9'h055) begin
      fail_cnt++;
      $display("FAIL reset_mid_rewrite: got %h, required 055", bus.rd_data);
    end
    assert_cnt++;
    if (err_cnt !== e0) begin
      fail_cnt++;
      $display("FAIL reset_mid_err: got %0d pulses, required 0", err_cnt - e0);
    end
    $display("test_reset_mid acks %b", acks);
  endtask

  initial begin
    test_reset();
    test_write_active();
    test_nack();
    test_reset_reg();
    test_invalid();
    test_extra_byte();
    test_truncated();
    test_reset_mid();
    repeat (20) @(posedge clk);
    assert_cnt++;
    if (exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL scoreboard_drain: got %0d pending commits, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/wm8731_i2c_target.md
# wm8731_i2c_target

Synthesizable I2C target that models the WM8731 codec's 2-wire control port. It decodes write transactions from the on-board I2C master, ACKs each byte, and splits every 16-bit word into a 7-bit register address and 9-bit data. It holds a shadow copy of the codec register map, so the configuration sequencer can be checked in simulation and in loopback on the FPGA without a codec.

## Interface
- DEV_ADDR, 7'h1A: 7-bit target address; the address byte on the wire is 0x34 (write), 0x35 (read).
- SYNC_STAGES, 2: synchronizer depth on SCL/SDA, minimum 2.
- clk  in  1  system clock; must be ≥ 20× SCL frequency.
- reset  in  1  asynchronous, active-high reset.
- i2c_scl  in  1  I2C clock from the master.
- i2c_sda  inout  1  I2C data; open-drain; the block only drives 0 or 'z'.
- wr_valid  out  1  one-clk pulse when a register write commits.
- wr_addr  out  7  register address of the last commit.
- wr_data  out  9  data of the last commit.
- rd_addr  in  4  readback index into the register file.
- rd_data  out  9  combinational register-file readback.
- codec_active  out  1  register 0x09 bit 0.
- bus_busy  out  1  high from START to STOP.
- err_pulse  out  1  one-clk pulse on an invalid register address, an extra byte, or a truncated word.

## Operation
- **Sampling.** SCL and SDA each pass through a SYNC_STAGES flop synchronizer and then one edge register.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data bits are sampled on the SCL rising edge, MSB first.
- **FSM states.** IDLE, ADDR, ADDR_ACK, BYTE_HI, ACK_HI, BYTE_LO, ACK_LO, IGNORE.
- **Transitions.**
  - IDLE → ADDR on START.
  - ADDR: shift 8 bits.
    - Address matches DEV_ADDR and R/W = 0 → ADDR_ACK.
    - Otherwise → IGNORE (NACK: SDA not driven).
  - ADDR_ACK → BYTE_HI. BYTE_HI (8 bits) → ACK_HI → BYTE_LO (8 bits) → ACK_LO.
  - Word split: wr_addr = byte_hi[7:1]; wr_data = {byte_hi[0], byte_lo}.
  - Commit happens on the 8th BYTE_LO bit. It updates wr_addr and wr_data and pulses wr_valid.
  - ACK_LO → IGNORE. Any further data byte is NACKed and pulses err_pulse once.
- **Repeated START** in any state → ADDR. A partial word is discarded with err_pulse.
- **STOP** in any state → IDLE. If it arrives mid-word (BYTE_HI, ACK_HI or BYTE_LO), err_pulse fires and nothing is written.
- **Register file.** 10 × 9-bit, indices 0x00–0x09.
  - Reset defaults: 0x097, 0x097, 0x079, 0x079, 0x00A, 0x008, 0x09F, 0x00A, 0x000, 0x000.
- **Address rules.**
  - Address 0x0F (reset register): any data restores all defaults. wr_valid still pulses.
  - Addresses 0x0A–0x0E and 0x10–0x7F are still ACKed. The file is unchanged, wr_valid stays low, err_pulse fires.
  - rd_addr > 9 reads 0.
- **Reset values.** wr_valid, err_pulse, bus_busy, wr_addr, wr_data = 0. SDA released. FSM in IDLE. Register file at defaults.
- **Reset mid-transaction.** SDA is released within the reset cycle. The block ignores the bus until the next START.

## Timing
- Pad-to-event latency is SYNC_STAGES + 1 clk.
- ACK drive: SDA is pulled low starting on the clk after the SCL falling edge that ends the 8th bit. It is released on the clk after the next SCL falling edge. SDA never changes while SCL is high.
- wr_valid is asserted the clk after the 16th data bit's SCL rise is detected, and lasts 1 clk.
- Register-file update and codec_active change are visible on that same clk.
- bus_busy rises the clk after START is detected and falls the clk after STOP is detected.
- START and STOP detection take priority over bit sampling in the same clk.

## Structure
- Package wm8731_pkg holds:
  - register index constants (REG_LLINE..REG_ACTIVE, REG_RESET = 7'h0F);
  - the default-value array;
  - the FSM state enum.
- One sub-module, i2c_bus_sync. It contains the synchronizer, the edge register, and the START/STOP/rise/fall strobes. It is reused by future I2C blocks.

## Test plan
- Write 0x34, 0x12, 0x01 (reg 0x09 = 0x001) → all three bytes ACKed; wr_valid pulse with wr_addr = 0x09, wr_data = 0x001; codec_active = 1.
- Address byte 0x36 → NACK; SDA never driven; no wr_valid; bus_busy toggles.
- Write reg 0x04 = 0x079, then reg 0x0F = 0x000 → rd_data at index 4 returns 0x079 after the first write and 0x00A after the second.
- Write 0x34, 0x1C, 0x00 (reg 0x0E, invalid) → ACKed; err_pulse; file unchanged.
- Write 0x34, 0x08, 0x12, 0x55 → the first word commits reg 0x04 = 0x012; the 4th byte is NACKed; err_pulse.
- Assert reset during BYTE_LO of a write to reg 0x00 → SDA released; reg 0 = 0x097; the next full write succeeds.
